// File: rtl/sel_stepper_if.sv
// Bundles the step request inputs and the select/pulse outputs of sel_stepper.
interface sel_stepper_if #(
    parameter int unsigned SEL_W = 3
);
    logic             a_in;
    logic             dir;
    logic             hold;
    logic             clr;
    logic [SEL_W-1:0] sel;
    logic             step_pulse;
    logic             wrap;

    modport master (
        output a_in, dir, hold, clr,
        input  sel, step_pulse, wrap
    );

    modport slave (
        input  a_in, dir, hold, clr,
        output sel, step_pulse, wrap
    );
endinterface

// File: rtl/sel_stepper.sv
// Wrapping up/down select counter stepped by rising edges of an asynchronous request level.
// Define SEL_STEPPER_DEBOUNCE_EN to insert a DB_CYCLES-cycle debouncer after the synchroniser.
module sel_stepper #(
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned SEL_MAX   = 7,
    parameter int unsigned DB_CYCLES = 4
) (
    input logic          clk,
    input logic          rst_n,
    sel_stepper_if.slave bus
);
    localparam logic [SEL_W-1:0] MaxVal = SEL_MAX[SEL_W-1:0];

    logic             s1_q, s2_q;
    logic             lvl;
    logic             lvl_dly_q;
    logic             step_evt;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             step_pulse_q, step_pulse_d;
    logic             wrap_q, wrap_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            lvl_dly_q <= 1'b0;
        end else begin
            s1_q      <= bus.a_in;
            s2_q      <= s1_q;
            lvl_dly_q <= lvl;
        end
    end

`ifdef SEL_STEPPER_DEBOUNCE_EN
    localparam logic [7:0] DbLast = 8'(DB_CYCLES - 1);

    logic       a_stable_q, a_stable_d;
    logic [7:0] db_cnt_q, db_cnt_d;

    // Any cycle where s2 agrees with the stable level restarts the count.
    always_comb begin
        a_stable_d = a_stable_q;
        db_cnt_d   = 8'd0;
        if (s2_q != a_stable_q) begin
            if (db_cnt_q == DbLast) begin
                a_stable_d = s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_stable_q <= 1'b0;
            db_cnt_q   <= 8'd0;
        end else begin
            a_stable_q <= a_stable_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    assign lvl = a_stable_q;
`else
    // DB_CYCLES has no effect without the debouncer.
    logic unused_db_cycles;
    assign unused_db_cycles = ^DB_CYCLES;
    assign lvl = s2_q;
`endif

    assign step_evt = lvl & ~lvl_dly_q;

    always_comb begin
        sel_d        = sel_q;
        step_pulse_d = 1'b0;
        wrap_d       = 1'b0;
        if (bus.clr) begin
            sel_d = '0;
        end else if (step_evt && !bus.hold) begin
            step_pulse_d = 1'b1;
            if (!bus.dir) begin
                if (sel_q == MaxVal) begin
                    sel_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                end
            end else begin
                if (sel_q == '0) begin
                    sel_d  = MaxVal;
                    wrap_d = 1'b1;
                end else begin
                    sel_d = sel_q - SEL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q        <= '0;
            step_pulse_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            step_pulse_q <= step_pulse_d;
            wrap_q       <= wrap_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.wrap       = wrap_q;
endmodule

// File: doc/sel_stepper.md
SEL_STEPPER -- requirements
Module: sel_stepper

Interface
REQ-001 Parameter SEL_W, default 3, sets the width of the select output.
REQ-002 Parameter SEL_MAX, default 7, is the highest select value before wrap; legal range 1..2^SEL_W-1.
REQ-003 Parameter DB_CYCLES, default 4, is the number of stable cycles required by the debouncer; legal range 1..255.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 a_in  input  1  step request, asynchronous to clk (switch/button level).
REQ-007 dir  input  1  step direction: 0 = increment, 1 = decrement; sampled in the step cycle.
REQ-008 hold  input  1  when high, detected steps are discarded.
REQ-009 clr  input  1  synchronous clear of sel to 0.
REQ-010 sel  output  SEL_W  current select value, registered.
REQ-011 step_pulse  output  1  one-cycle pulse, high in the cycle sel takes a stepped value.
REQ-012 wrap  output  1  one-cycle pulse, high when a step crossed SEL_MAX<->0.

Function
REQ-013 a_in passes a two-flop synchroniser (s1, s2) before any other use.
REQ-014 Debouncer: a_stable follows s2 only after s2 differs from a_stable for DB_CYCLES consecutive cycles; any cycle with s2 == a_stable clears the 8-bit debounce counter.
REQ-015 A step event is a 0->1 transition of the conditioned level (a_stable, or s2 with debounce compiled out), detected against a one-cycle delayed copy.
REQ-016 A step with dir=0 sets sel to sel+1, or to 0 with wrap=1 if sel == SEL_MAX.
REQ-017 A step with dir=1 sets sel to sel-1, or to SEL_MAX with wrap=1 if sel == 0.
REQ-018 step_pulse and wrap are registered, asserted in the same cycle as the new sel value, and low otherwise.
REQ-019 Latency (debounce out): sel changes on the 3rd rising clk edge after a_in rises with setup met.
REQ-020 Latency (debounce in): sel changes on the (3+DB_CYCLES)th rising clk edge after a_in rises.
REQ-021 Falling transitions of the conditioned level never step.
REQ-022 hold=1 in the step cycle: event is consumed, sel unchanged, step_pulse=0, wrap=0; no event is queued.
REQ-023 clr=1 has priority over a simultaneous step: sel=0, step_pulse=0, wrap=0.
REQ-024 sel never exceeds SEL_MAX.
REQ-025 A pulse on a_in shorter than DB_CYCLES cycles (after synchronisation) produces no step when debounce is compiled in.

Reset
REQ-026 rst_n low asynchronously sets sel=0, step_pulse=0, wrap=0, s1=s2=0, a_stable=0, delayed copy=0, debounce counter=0.
REQ-027 Release of rst_n is taken synchronously; a_in held high through release yields exactly one step once conditioned.
REQ-028 Reset asserted mid-debounce or mid-step discards the pending event; no step after release unless REQ-027 applies.

Configuration
REQ-029 Macro SEL_STEPPER_DEBOUNCE_EN defined: debouncer of REQ-014/REQ-025 is compiled in and DB_CYCLES is honoured.
REQ-030 Macro SEL_STEPPER_DEBOUNCE_EN undefined: debouncer and counter are absent, s2 feeds edge detection directly, and DB_CYCLES is ignored.

Verification
REQ-031 Debounce out, defaults, dir=0: 8 clean a_in pulses (4 cycles high/4 low) -> sel 1..7 then 0; wrap=1 only on the 7->0 step; 8 step_pulses.
REQ-032 dir=1 from reset: one a_in pulse -> sel=7, wrap=1, step_pulse=1 for exactly one cycle.
REQ-033 Debounce in, DB_CYCLES=4: 3-cycle a_in glitch -> no step; 6-cycle pulse -> one step, sel changes 7 edges after a_in rise.
REQ-034 hold=1 during the step cycle of a pulse at sel=3 -> sel stays 3, no pulse; next pulse with hold=0 -> sel=4.
REQ-035 clr=1 coincident with a step at sel=5 -> sel=0, step_pulse=0; rst_n pulled low at sel=6 mid-clock -> sel=0 immediately, outputs 0.
REQ-036 SEL_W=4, SEL_MAX=9: 10 up-steps -> sel 1..9 then 0, wrap on the 9->0 step; sel never reaches 10.
